// File: rtl/seq_detect_pkg.sv
// Shared types and reset defaults for the programmable serial-pattern detector.
package seq_detect_pkg;

    localparam int LENW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0]      DEF_PATTERN = 8'h0A;
    localparam logic [LENW-1:0] DEF_LEN     = 4'd4;
    localparam logic            DEF_OVERLAP = 1'b0;

    function automatic logic len_legal(input logic [LENW-1:0] len, input int maxlen);
        return (len != '0) && (int'(len) <= maxlen);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and the combinational pattern compare.
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int MAXLEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift,
    input  logic              clear,
    input  logic              restart_fill,
    input  logic              b,
    input  logic [MAXLEN-1:0] pattern,
    input  logic [LENW-1:0]   len,
    output logic              hit
);

    logic [MAXLEN-1:0] hist;
    logic [LENW-1:0]   fill;
    logic [MAXLEN-1:0] window;
    logic [MAXLEN-1:0] mask;
    logic              full;

    assign window = {hist[MAXLEN-2:0], b};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAXLEN; i++)
            mask[i] = (i < int'(len));
    end

    // The completing bit arrives with this cycle's b, so len-1 stored bits suffice.
    assign full = ({1'b0, fill} + 5'd1) >= {1'b0, len};
    assign hit  = shift && full && (((window ^ pattern) & mask) == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= window;
            if (restart_fill)
                fill <= '0;
            else if (fill >= len)
                fill <= len;
            else
                fill <= fill + 4'd1;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Detector controller: configuration handshake, arm/done FSM and match counter.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LENW-1:0]   cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_target,
    output logic              cfg_err,
    input  logic              start,
    input  logic              abort,
    input  logic              bit_valid,
    input  logic              b,
    output logic              a,
    output logic              busy,
    output logic              done,
    output logic [CNTW-1:0]   match_count
);

    state_t            state, state_nxt;
    logic [MAXLEN-1:0] pat_q;
    logic [LENW-1:0]   len_q;
    logic              ovl_q;
    logic [CNTW-1:0]   tgt_q;

    logic              hs, len_ok, arm, shift, hit;
    logic [CNTW-1:0]   cnt_inc;
    logic              tgt_hit;

    assign hs      = cfg_valid && (state == IDLE);
    assign len_ok  = len_legal(cfg_len, MAXLEN);
    assign arm     = start && !abort && (state != ARMED);
    assign shift   = (state == ARMED) && bit_valid && !abort;
    assign cnt_inc = match_count + {{(CNTW-1){1'b0}}, 1'b1};
    assign tgt_hit = a && (tgt_q != '0) && (cnt_inc == tgt_q);

    seq_match_core #(.MAXLEN(MAXLEN)) u_core (
        .clk          (clk),
        .reset        (reset),
        .shift        (shift),
        .clear        (arm),
        .restart_fill (hit && !ovl_q),
        .b            (b),
        .pattern      (pat_q),
        .len          (len_q),
        .hit          (hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort)
            state_nxt = IDLE;
        else begin
            case (state)
                IDLE:    if (start)   state_nxt = ARMED;
                ARMED:   if (tgt_hit) state_nxt = DONE;
                DONE:    if (start)   state_nxt = ARMED;
                default:              state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ready = (state == IDLE);
        busy      = (state == ARMED);
        done      = (state == DONE);
        a         = (state == ARMED) && !abort && hit;
    end

    // A handshake in the arming cycle lands before the first shift, so it governs this arm.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q   <= MAXLEN'(DEF_PATTERN);
            len_q   <= DEF_LEN;
            ovl_q   <= DEF_OVERLAP;
            tgt_q   <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= hs && !len_ok;
            if (hs && len_ok) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                ovl_q <= cfg_overlap;
                tgt_q <= cfg_target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            match_count <= '0;
        else if (arm)
            match_count <= '0;
        else if (a && (match_count != '1))
            match_count <= cnt_inc;
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench with a bit-list reference model compared every cycle.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_pattern = 8'h00;
    logic [3:0] cfg_len = 4'd0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_target = 8'h00;
    logic       cfg_err;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bit_valid = 1'b0;
    logic       b = 1'b0;
    logic       a;
    logic       busy;
    logic       done;
    logic [7:0] match_count;

    int tests = 0;
    int fails = 0;
    logic [31:0] amask;

    seq_detect_ctrl #(.MAXLEN(8), .CNTW(8)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_target(cfg_target), .cfg_err(cfg_err), .start(start), .abort(abort),
        .bit_valid(bit_valid), .b(b), .a(a), .busy(busy), .done(done),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    // Reference model: state 0 idle, 1 armed, 2 done; bits received since arm kept as a list.
    int   m_st = 0;
    int   m_cnt = 0;
    int   m_run = 0;
    bit   m_err = 0;
    bit   m_pat[8];
    int   m_len = 4;
    bit   m_ov = 0;
    int   m_tgt = 0;
    bit   q[$];

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) m_pat[i] = (i == 1 || i == 3);
        m_len = 4; m_ov = 0; m_tgt = 0;
        m_st = 0; m_cnt = 0; m_run = 0; m_err = 0;
        q.delete();
    endfunction

    initial m_reset();

    function automatic bit model_a();
        bit ok;
        if (m_st != 1 || abort || !bit_valid) return 0;
        if (m_run + 1 < m_len) return 0;
        ok = (b == m_pat[0]);
        for (int i = 1; i < m_len; i++)
            if (q[q.size() - i] != m_pat[i]) ok = 0;
        return ok;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_reset();
        end else begin
            bit ea, hs, legal;
            ea    = model_a();
            hs    = cfg_valid && (m_st == 0);
            legal = (cfg_len >= 1) && (cfg_len <= 8);
            m_err = hs && !legal;
            if (hs && legal) begin
                for (int i = 0; i < 8; i++) m_pat[i] = cfg_pattern[i];
                m_len = int'(cfg_len); m_ov = cfg_overlap; m_tgt = int'(cfg_target);
            end
            if (abort) m_st = 0;
            else if (m_st == 1) begin
                if (bit_valid) begin
                    q.push_back(b);
                    if (q.size() > 16) void'(q.pop_front());
                    if (ea) begin
                        if (m_cnt != 255) m_cnt++;
                        m_run = m_ov ? m_run + 1 : 0;
                        if (m_tgt != 0 && m_cnt == m_tgt) m_st = 2;
                    end else m_run++;
                end
            end else if (start) begin
                m_st = 1; m_cnt = 0; m_run = 0; q.delete();
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a", {31'd0, a}, {31'd0, model_a()});
        chk("busy", {31'd0, busy}, {31'd0, m_st == 1});
        chk("done", {31'd0, done}, {31'd0, m_st == 2});
        chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, m_st == 0});
        chk("cfg_err", {31'd0, cfg_err}, {31'd0, m_err});
        chk("match_count", {24'd0, match_count}, m_cnt);
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov,
                       input logic [7:0] t, input logic st);
        cfg_valid = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_target = t; start = st;
        cyc();
        cfg_valid = 0; start = 0;
    endtask

    task automatic arm();
        start = 1; cyc(); start = 0;
    endtask

    task automatic send(input logic v, input int idx, input logic ab);
        bit_valid = 1; b = v; abort = ab;
        @(negedge clk);
        if (a) amask[idx] = 1'b1;
        @(posedge clk); #1;
        bit_valid = 0; abort = 0;
    endtask

    task automatic stream15();
        logic [14:0] s;
        s = 15'b110101011101010;
        amask = 0;
        for (int i = 0; i < 15; i++) send(s[14-i], i + 1, 1'b0);
    endtask

    initial begin
        #2;
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        cyc(); cyc();
        reset = 1;
        cyc();

        // illegal lengths keep the defaults
        cfg(8'hFF, 4'd0, 1'b1, 8'd1, 1'b0);
        chk("err_len0", {31'd0, cfg_err}, 32'd1);
        cfg(8'hFF, 4'd9, 1'b1, 8'd1, 1'b0);
        chk("err_len9", {31'd0, cfg_err}, 32'd1);
        cyc();
        chk("err_clear", {31'd0, cfg_err}, 32'd0);

        arm();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        stream15();
        chk("def_amask", amask, 32'h0000_2020);
        chk("def_count", {24'd0, match_count}, 32'd2);
        abort = 1; cyc(); abort = 0;
        chk("abort_idle", {31'd0, cfg_ready}, 32'd1);
        chk("abort_hold_cnt", {24'd0, match_count}, 32'd2);

        cfg(8'h0A, 4'd4, 1'b1, 8'd0, 1'b1);
        stream15();
        chk("ovl_amask", amask, 32'h0000_A0A0);
        chk("ovl_count", {24'd0, match_count}, 32'd4);
        abort = 1; cyc(); abort = 0;

        cfg(8'h0A, 4'd4, 1'b1, 8'd2, 1'b1);
        stream15();
        chk("tgt_amask", amask, 32'h0000_00A0);
        chk("tgt_done", {31'd0, done}, 32'd1);
        chk("tgt_count", {24'd0, match_count}, 32'd2);
        abort = 1; cyc(); abort = 0;

        cfg(8'h0A, 4'd4, 1'b0, 8'd0, 1'b1);
        amask = 0;
        for (int i = 0; i < 4; i++) begin
            send((i % 2) == 0, i + 1, 1'b0);
            if (i < 3) begin cyc(); cyc(); cyc(); end
        end
        chk("gap_amask", amask, 32'h0000_0010);
        chk("gap_count", {24'd0, match_count}, 32'd1);
        abort = 1; cyc(); abort = 0;

        cfg(8'b101, 4'd3, 1'b1, 8'd0, 1'b1);
        amask = 0;
        for (int i = 0; i < 5; i++) send((i % 2) == 0, i + 1, 1'b0);
        chk("p101_amask", amask, 32'h0000_0028);
        chk("p101_count", {24'd0, match_count}, 32'd2);
        abort = 1; cyc(); abort = 0;

        // abort coincident with a completing bit suppresses the match
        cfg(8'h0A, 4'd4, 1'b0, 8'd0, 1'b1);
        amask = 0;
        send(1, 1, 0); send(0, 2, 0); send(1, 3, 0); send(0, 4, 1);
        chk("abort_amask", amask, 32'h0);
        chk("abort_cnt", {24'd0, match_count}, 32'd0);
        chk("abort_state", {31'd0, cfg_ready}, 32'd1);

        // asynchronous reset mid-stream
        cfg(8'h0A, 4'd4, 1'b1, 8'd0, 1'b1);
        send(1, 1, 0); send(0, 2, 0); send(1, 3, 0); send(0, 4, 0);
        send(1, 5, 0); send(0, 6, 0);
        chk("pre_rst_cnt", {24'd0, match_count}, 32'd2);
        #2 reset = 0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("mid_rst_cnt", {24'd0, match_count}, 32'd0);
        cyc();
        reset = 1;
        cyc();
        arm();
        amask = 0;
        send(1, 1, 0); send(0, 2, 0); send(1, 3, 0); send(0, 4, 0);
        chk("post_rst_amask", amask, 32'h0000_0010);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable serial-pattern detection controller for the sequence-detector family. It accepts a pattern configuration through a valid/ready handshake and arms on `start`. While armed it watches the qualified serial input `b` and emits a Mealy `a` pulse on each match, in overlapping or non-overlapping mode. It counts matches and finishes after a programmable target count.

## Interface
Parameters:
- `MAXLEN`, 8: maximum pattern length in bits; also the width of the pattern and history registers.
- `CNTW`, 8: width of the match counter and the target.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `cfg_valid` input 1: a configuration word is presented.
- `cfg_ready` output 1: high only in IDLE.
- `cfg_pattern` input MAXLEN: pattern. Bit `len-1` is the first bit received; bit 0 is the last.
- `cfg_len` input 4: pattern length; legal range 1..MAXLEN.
- `cfg_overlap` input 1: 1 = overlapping, 0 = non-overlapping.
- `cfg_target` input CNTW: number of matches to reach DONE; 0 = unlimited.
- `cfg_err` output 1: one-cycle pulse when a handshake carries an illegal `cfg_len`.
- `start` input 1: arm the detector.
- `abort` input 1: return to IDLE.
- `bit_valid` input 1: `b` is qualified this cycle.
- `b` input 1: serial data.
- `a` output 1: Mealy match pulse.
- `busy` output 1: high in ARMED.
- `done` output 1: high in DONE.
- `match_count` output CNTW: matches counted since the last arm.

## Operation
- **Reset:**
  - State goes to IDLE.
  - Configuration defaults: pattern 8'h0A, len 4, overlap 0, target 0. This is the "1010" non-overlapping detector.
  - History, fill counter and `match_count` clear to 0.
  - Outputs `a`, `busy`, `done` and `cfg_err` are 0; `cfg_ready` is 1.
- **IDLE:**
  - A handshake (`cfg_valid && cfg_ready`) latches the configuration if `cfg_len` is in 1..MAXLEN.
  - If `cfg_len` is illegal, the configuration is left unchanged and `cfg_err` pulses for one cycle.
  - `start` moves to ARMED and clears history, fill counter and `match_count`.
  - If `start` and a handshake occur in the same cycle, the new configuration is latched and used for this arm.
- **ARMED:**
  - On each `bit_valid`, the history shifts left with `b` entering at the LSB, and the fill counter increments, saturating at `len`.
  - Match condition: `bit_valid`, fill ≥ `len-1`, and the low `len` bits of {history, `b`} equal the low `len` bits of the pattern.
  - `a` is a combinational function of the current inputs and state; it is high only in ARMED.
  - On a match, `match_count` increments.
  - Non-overlapping mode: the fill counter is forced to 0 on a match.
  - Overlapping mode: the fill counter stays saturated.
  - If `cfg_target` ≠ 0 and the incremented count equals the target, move to DONE.
  - Cycles with `bit_valid` = 0 change nothing.
  - `start` is ignored in ARMED.
  - `cfg_valid` is not accepted in ARMED.
- **DONE:**
  - `done` is high and `match_count` holds its value.
  - `start` re-arms: clear state, go to ARMED.
  - `abort` goes to IDLE.
- **abort:** goes to IDLE from any state and has priority over `start` and over matches. `match_count` holds its value in IDLE. `a` is 0 in any cycle with `abort` = 1.
- **Counter limit:** with target 0, `match_count` saturates at all-ones.

## Timing
- `a` has zero latency: it is high in the same cycle as the completing `b`.
- `match_count` updates at the next rising edge.
- On the final target match, `a` = 1 in that cycle; `done` rises the next cycle.
- `busy` goes high the cycle after `start`.
- `cfg_err` is registered: it appears the cycle after the illegal handshake.
- Asserting `reset` mid-stream clears everything immediately (asynchronously). The first match after release needs `len` fresh valid bits.

## Structure
- Shared package `seq_detect_pkg`:
  - state enum {IDLE, ARMED, DONE}.
  - default constants DEF_PATTERN = 8'h0A, DEF_LEN = 4, DEF_OVERLAP = 0.
- Sub-module `seq_match_core`:
  - Holds the history shift register and fill counter.
  - Computes the combinational match.
  - Takes inputs shift, clear, restart-fill, pattern and len.
- The top level holds the FSM, configuration registers, counter and handshake.

## Test plan
- Defaults after reset. Stream 1,1,0,1,0,1,0,1,1,1,0,1,0,1,0, one valid bit per cycle → `a` high on bits 5 and 13 only; `match_count` = 2.
- Same stream with `cfg_overlap` = 1 → `a` on bits 5, 7, 13 and 15; `match_count` = 4.
- `cfg_target` = 2 in overlapping mode → `done` rises the cycle after bit 7; bits 8–15 produce no `a`; `match_count` = 2.
- `bit_valid` gaps: insert 3 invalid cycles between every bit of 1,0,1,0 → exactly one `a`, aligned with the fourth valid bit.
- Config errors:
  - `cfg_len` = 0 → `cfg_err` pulses and the default configuration is kept.
  - Pattern 8'b101, len 3, overlap 1, stream 1,0,1,0,1 → `a` on bits 3 and 5.
- Abort and reset mid-stream:
  - `abort` in the same cycle as a completing bit → `a` = 0 and the state goes to IDLE.
  - `reset` low mid-stream → all outputs go to their reset values immediately.
